onehot_rr_arbiter: RTL and testbench
====================================

Name: onehot_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource between N requesters.
- Produces a registered one-hot grant plus its binary index, in the same one-hot/binary form consumed by the team's encoder blocks.
- Enforces a minimum one-cycle gap between owners and an optional maximum hold time.
- Sits between requesting user-area blocks and the shared datapath port.

Parameters:
N, 64, number of requesters; power of two, >= 2
MAX_HOLD, 16, max consecutive grant cycles while others wait; 0 disables the limit

Ports:
wb_clk_i  input  1  clock, all logic on rising edge
wb_rst_i  input  1  synchronous active-high reset
req_i  input  N  request vector, bit i = requester i
release_i  input  1  holder finished; ends current grant
grant_o  output  N  registered one-hot grant, all-zero when idle
grant_id_o  output  $clog2(N)  binary index of grant_o bit; 0 when idle
grant_valid_o  output  1  high iff grant_o != 0
timeout_o  output  1  one-cycle pulse when a grant is force-ended by MAX_HOLD

Behaviour:
- Reset (wb_rst_i high at edge):
  - grant_o=0, grant_id_o=0, grant_valid_o=0, timeout_o=0.
  - Priority pointer ptr=0, hold counter=0, state=IDLE.
  - Applies mid-grant as well: the grant is dropped at that edge, with no timeout pulse.
- States: IDLE, GRANTED.
- IDLE:
  - If req_i!=0, select the first set bit k searching ptr, ptr+1, ... N-1, 0, ... ptr-1 (wrap modulo N).
  - At the next edge: grant_o=1<<k, grant_id_o=k, grant_valid_o=1, ptr<=(k+1) mod N, counter<=0, state->GRANTED.
  - Latency is 1 cycle from request sampled to grant visible.
  - release_i is ignored in IDLE.
- GRANTED:
  - Grant is held and outputs are stable.
  - Requests from non-holders are ignored until the grant ends.
  - The counter increments each cycle, saturating at MAX_HOLD-1.
- Grant ends when any of the following is sampled at an edge:
  - (a) release_i=1.
  - (b) req_i[holder]=0.
  - (c) MAX_HOLD!=0 and counter==MAX_HOLD-1 and (req_i with holder bit masked)!=0.
- On grant end:
  - Next edge: outputs return to idle values and state->IDLE.
  - No new grant in that same cycle, so grant_o is 0 for at least one cycle between owners.
- timeout_o is 1 for exactly the cycle after the edge that ended a grant by (c) alone. If (a) or (b) also holds, there is no timeout pulse.
- With a single requester and MAX_HOLD reached, the grant persists indefinitely and no timeout fires.
- grant_o is always zero or one-hot. grant_id_o always equals the binary encoding of grant_o.
- ptr advances only when a grant is issued, never on release.
- X/unknown inputs are not required to be handled; the bench drives known values.

Test Plan:
All scenarios use N=8, MAX_HOLD=4.
1. Reset: assert wb_rst_i 2 cycles with req_i=0xFF -> grant_o=0x00, grant_id_o=0, grant_valid_o=0, timeout_o=0; first grant after reset release goes to bit 0.
2. Single grant/release: req_i=0x01 -> next cycle grant_o=0x01, grant_id_o=0, valid=1; pulse release_i -> grant_o=0x00 next cycle.
3. Round-robin fairness: req_i=0xFF held, release_i pulsed one cycle after each grant -> grant_id_o sequence 0,1,2,3,4,5,6,7,0, with one idle cycle between each grant.
4. Wrap-around: grant bit 5 and release it, then req_i=0x09 -> search starts at 6 -> grant_o=0x01 (id 0); release -> grant_o=0x08 (id 3).
5. Timeout: req_i=0x03 held, no release -> grant 0x01 for exactly 4 cycles, timeout_o=1 for 1 cycle with grant_o=0, then grant_o=0x02. Also: req_i=0x01 alone for 12 cycles -> grant held throughout, timeout_o never asserted.
6. Reset mid-grant: grant_o=0x04 active, assert wb_rst_i one cycle -> grant_o=0 at that edge, timeout_o=0; with req_i=0x04 still high -> regrant 0x04 one cycle after reset deasserts.

Source files
------------

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter sharing one downstream port between N requesters.
// Issues a registered one-hot grant plus its binary index, leaves at least one
// idle cycle between owners, and can force a holder off after MAX_HOLD cycles
// when someone else is waiting.
//
// Ports:
//   wb_clk_i       clock, all logic on rising edge
//   wb_rst_i       synchronous active-high reset
//   req_i          request vector, bit i = requester i
//   release_i      holder finished; ends the current grant
//   grant_o        registered one-hot grant, zero when idle
//   grant_id_o     binary index of the grant_o bit, zero when idle
//   grant_valid_o  high iff grant_o is non-zero
//   timeout_o      one-cycle pulse when a grant was force-ended by MAX_HOLD
module onehot_rr_arbiter #(
  parameter int unsigned N        = 64,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [N-1:0]         req_i,
  input  logic                 release_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] grant_id_o,
  output logic                 grant_valid_o,
  output logic                 timeout_o
);

  localparam int unsigned IdW     = $clog2(N);
  localparam bit          HoldEn  = (MAX_HOLD != 0);
  localparam int unsigned HoldMax = HoldEn ? MAX_HOLD - 1 : 0;
  localparam int unsigned CntW    = (HoldMax > 0) ? $clog2(HoldMax + 1) : 1;
  localparam logic [N-1:0] GrantOne = N'(1);

  typedef enum logic [0:0] {StIdle, StGranted} state_e;

  state_e              state_q, state_d;
  logic [IdW-1:0]      ptr_q, ptr_d;
  logic [IdW-1:0]      id_q, id_d;
  logic [N-1:0]        grant_q, grant_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                timeout_q, timeout_d;

  // First requester at or after ptr_q, wrapping; IdW-bit add wraps modulo N.
  logic           found;
  logic [IdW-1:0] pick;
  logic [IdW-1:0] idx;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = ptr_q + IdW'(i);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  logic end_rel, end_drop, end_hold;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    end_rel   = 1'b0;
    end_drop  = 1'b0;
    end_hold  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = GrantOne << pick;
          id_d    = pick;
          ptr_d   = pick + IdW'(1);
          cnt_d   = '0;
          state_d = StGranted;
        end
      end
      StGranted: begin
        end_rel  = release_i;
        end_drop = !req_i[id_q];
        // Only forced off when another requester is actually waiting.
        end_hold = HoldEn && (cnt_q == CntW'(HoldMax)) && |(req_i & ~grant_q);
        if (end_rel || end_drop || end_hold) begin
          grant_d   = '0;
          id_d      = '0;
          cnt_d     = '0;
          state_d   = StIdle;
          timeout_d = end_hold && !end_rel && !end_drop;
        end else if (cnt_q != CntW'(HoldMax)) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      id_q      <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_id_o    = id_q;
  assign grant_valid_o = |grant_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
module tb_onehot_rr_arbiter;

  localparam int unsigned N  = 8;
  localparam int unsigned MH = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         rel;
  logic [N-1:0] grant_o;
  logic [2:0]   grant_id_o;
  logic         grant_valid_o;
  logic         timeout_o;

  onehot_rr_arbiter #(
    .N        (N),
    .MAX_HOLD (MH)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .req_i         (req),
    .release_i     (rel),
    .grant_o       (grant_o),
    .grant_id_o    (grant_id_o),
    .grant_valid_o (grant_valid_o),
    .timeout_o     (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] id;
    logic       v;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Behavioural reference state.
  bit m_valid;
  int m_id;
  int m_ptr;
  int m_cnt;
  bit m_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, want);
    end
  endtask

  task automatic model(input logic [7:0] r, input logic rl, input logic rs);
    bit a, b, c, hit;
    m_to = 1'b0;
    if (rs) begin
      m_valid = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_valid) begin
      hit = 0;
      for (int off = 0; off < 8; off++) begin
        if (!hit && r[(m_ptr + off) % 8]) begin
          hit     = 1;
          m_id    = (m_ptr + off) % 8;
          m_ptr   = (m_id + 1) % 8;
          m_valid = 1;
          m_cnt   = 0;
        end
      end
    end else begin
      a = rl;
      b = !r[m_id];
      c = (m_cnt == MH - 1) && ((r & ~(8'h01 << m_id)) != 8'h00);
      if (a || b || c) begin
        m_valid = 0; m_id = 0; m_cnt = 0;
        m_to = c && !a && !b;
      end else if (m_cnt < MH - 1) begin
        m_cnt++;
      end
    end
  endtask

  // Drive one cycle, queue the predicted post-edge outputs, then compare.
  task automatic step(input logic [7:0] r, input logic rl, input logic rs);
    exp_t e;
    exp_t got;
    req = r; rel = rl; rst = rs;
    model(r, rl, rs);
    e.g  = m_valid ? (8'h01 << m_id) : 8'h00;
    e.id = 3'(m_id);
    e.v  = m_valid;
    e.to = m_to;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      got = exp_q.pop_front();
      check("sb_grant", 32'(grant_o), 32'(got.g));
      check("sb_id", 32'(grant_id_o), 32'(got.id));
      check("sb_valid", 32'(grant_valid_o), 32'(got.v));
      check("sb_timeout", 32'(timeout_o), 32'(got.to));
    end
  endtask

  initial begin
    req = '0; rel = 1'b0; rst = 1'b1;
    m_valid = 0; m_id = 0; m_ptr = 0; m_cnt = 0; m_to = 0;

    // Reset held with all requests active.
    step(8'hFF, 1'b0, 1'b1);
    step(8'hFF, 1'b0, 1'b1);
    check("rst_grant", 32'(grant_o), 32'h00);
    check("rst_valid", 32'(grant_valid_o), 32'h0);
    check("rst_timeout", 32'(timeout_o), 32'h0);
    step(8'hFF, 1'b0, 1'b0);
    check("rst_first_grant", 32'(grant_o), 32'h01);
    step(8'hFF, 1'b1, 1'b0);
    check("rst_first_release", 32'(grant_o), 32'h00);

    // Single grant and release.
    step(8'h01, 1'b0, 1'b0);
    check("single_grant", 32'(grant_o), 32'h01);
    check("single_valid", 32'(grant_valid_o), 32'h1);
    step(8'h01, 1'b1, 1'b0);
    check("single_release", 32'(grant_o), 32'h00);

    // Fairness sweep from a fresh pointer.
    step(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b0, 1'b0);
      check("rr_id", 32'(grant_id_o), 32'(i % 8));
      step(8'hFF, 1'b1, 1'b0);
      check("rr_gap", 32'(grant_o), 32'h00);
    end

    // Wrap-around of the search start.
    step(8'h20, 1'b0, 1'b0);
    check("wrap_g5", 32'(grant_o), 32'h20);
    step(8'h20, 1'b1, 1'b0);
    step(8'h09, 1'b0, 1'b0);
    check("wrap_g0", 32'(grant_o), 32'h01);
    step(8'h09, 1'b1, 1'b0);
    step(8'h09, 1'b0, 1'b0);
    check("wrap_g3", 32'(grant_o), 32'h08);
    check("wrap_id3", 32'(grant_id_o), 32'd3);
    step(8'h00, 1'b1, 1'b0);

    // Hold limit with a competitor waiting.
    for (int i = 0; i < 4; i++) begin
      step(8'h03, 1'b0, 1'b0);
      check("to_hold", 32'(grant_o), 32'h01);
      check("to_nopulse", 32'(timeout_o), 32'h0);
    end
    step(8'h03, 1'b0, 1'b0);
    check("to_pulse", 32'(timeout_o), 32'h1);
    check("to_gap", 32'(grant_o), 32'h00);
    step(8'h03, 1'b0, 1'b0);
    check("to_next", 32'(grant_o), 32'h02);
    check("to_clear", 32'(timeout_o), 32'h0);
    step(8'h00, 1'b0, 1'b0);

    // Lone requester is never forced off.
    for (int i = 0; i < 12; i++) begin
      step(8'h01, 1'b0, 1'b0);
      check("solo_hold", 32'(grant_o), 32'h01);
      check("solo_timeout", 32'(timeout_o), 32'h0);
    end
    step(8'h00, 1'b0, 1'b0);

    // Reset in the middle of a grant.
    step(8'h04, 1'b0, 1'b0);
    check("mid_grant", 32'(grant_o), 32'h04);
    step(8'h04, 1'b0, 1'b0);
    step(8'h04, 1'b0, 1'b1);
    check("mid_rst_grant", 32'(grant_o), 32'h00);
    check("mid_rst_timeout", 32'(timeout_o), 32'h0);
    step(8'h04, 1'b0, 1'b0);
    check("mid_regrant", 32'(grant_o), 32'h04);

    // Release coinciding with the hold limit suppresses the pulse.
    for (int i = 0; i < 3; i++) step(8'h05, 1'b0, 1'b0);
    check("lim_holder", 32'(grant_o), 32'h04);
    step(8'h05, 1'b1, 1'b0);
    check("lim_rel_timeout", 32'(timeout_o), 32'h0);
    check("lim_rel_grant", 32'(grant_o), 32'h00);
    step(8'h00, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
